reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp_pkg.sv | 18 +
 rtl/reg_file_scoreboard.sv | 70 +++++++
 rtl/reg_file_mp.sv | 113 +++++++++++
 tb/tb_reg_file_mp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults, the hard-wired zero address and port-slice helpers for reg_file_mp.
package reg_file_mp_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned ZERO_ADDR      = 0;

  // Low bit of port idx inside a flattened bus of width-bit slices
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  // High bit of port idx inside a flattened bus of width-bit slices
  function automatic int unsigned slice_hi(input int unsigned idx, input int unsigned width);
    return (idx + 1) * width - 1;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Busy-bit scoreboard: reserve sets, any write clears, reserve wins; per-read-port lookup.
module reg_file_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_WR-1:0]            WE,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] WADDR,
  input  logic                         RSV_EN,
  input  logic [ADDR_WIDTH-1:0]        RSV_ADDR,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RADDR,
  output logic [NUM_RD-1:0]            RBUSY
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;
  logic [ADDR_WIDTH-1:0] waddr_a [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr_a [NUM_RD];

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wsplit
    assign waddr_a[k] = WADDR[slice_hi(k, ADDR_WIDTH):slice_lo(k, ADDR_WIDTH)];
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rsplit
    assign raddr_a[j] = RADDR[slice_hi(j, ADDR_WIDTH):slice_lo(j, ADDR_WIDTH)];
  end

  // Next busy vector: writes retire the producer, a reserve installs a new one
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_WR; k++) begin
      if (WE[k]) busy_d[waddr_a[k]] = 1'b0;
    end
    if (RSV_EN) busy_d[RSV_ADDR] = 1'b1;
    if (ZERO_REG != 0) busy_d[ADDR_WIDTH'(ZERO_ADDR)] = 1'b0;
  end

  // Busy vector register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_lookup
    logic hit_c;
    logic rbusy_c;

    // Busy lookup; a same-cycle write (not re-reserved) already satisfies the reader
    always_comb begin
      hit_c = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (WE[k] && (waddr_a[k] == raddr_a[j])) hit_c = 1'b1;
      end
      rbusy_c = busy_q[raddr_a[j]];
      if ((BYPASS != 0) && hit_c && !(RSV_EN && (RSV_ADDR == raddr_a[j]))) rbusy_c = 1'b0;
      if (!RESET_N) rbusy_c = 1'b0;
    end

    assign RBUSY[j] = rbusy_c;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port flip-flop register file with optional zero register, write bypass and busy scoreboard.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_WR-1:0]            WE,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] WADDR,
  input  logic [NUM_WR*DATA_WIDTH-1:0] WDATA,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] RADDR,
  output logic [NUM_RD*DATA_WIDTH-1:0] RDATA,
  output logic [NUM_RD-1:0]            RBUSY,
  input  logic                         RSV_EN,
  input  logic [ADDR_WIDTH-1:0]        RSV_ADDR,
  input  logic [ADDR_WIDTH-1:0]        DBG_ADDR,
  output logic [DATA_WIDTH-1:0]        DBG_DATA,
  output logic                         WR_CONFLICT
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic                  wr_conflict_q;
  logic                  conflict_c;
  logic [ADDR_WIDTH-1:0] waddr_a [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_WR];
  logic [ADDR_WIDTH-1:0] raddr_a [NUM_RD];

  // True when the address is the hard-wired zero register
  function automatic logic addr_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == ADDR_WIDTH'(ZERO_ADDR));
  endfunction

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wsplit
    assign waddr_a[k] = WADDR[slice_hi(k, ADDR_WIDTH):slice_lo(k, ADDR_WIDTH)];
    assign wdata_a[k] = WDATA[slice_hi(k, DATA_WIDTH):slice_lo(k, DATA_WIDTH)];
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rsplit
    assign raddr_a[j] = RADDR[slice_hi(j, ADDR_WIDTH):slice_lo(j, ADDR_WIDTH)];
  end

  // Two enabled write ports on the same real register
  always_comb begin
    conflict_c = 1'b0;
    for (int a = 0; a < NUM_WR; a++) begin
      for (int b = a + 1; b < NUM_WR; b++) begin
        if (WE[a] && WE[b] && (waddr_a[a] == waddr_a[b]) && !addr_zero(waddr_a[a]))
          conflict_c = 1'b1;
      end
    end
  end

  // Storage and conflict flag; later ports overwrite earlier ones on a collision
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (WE[k] && !addr_zero(waddr_a[k])) regs_q[waddr_a[k]] <= wdata_a[k];
      end
      wr_conflict_q <= conflict_c;
    end
  end

  assign WR_CONFLICT = wr_conflict_q;

  for (genvar j = 0; j < NUM_RD; j++) begin : g_read
    logic [DATA_WIDTH-1:0] rd_c;

    // Stored value, overridden by the highest-index matching write when bypassing
    always_comb begin
      rd_c = regs_q[raddr_a[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (WE[k] && (waddr_a[k] == raddr_a[j])) rd_c = wdata_a[k];
        end
      end
      if (addr_zero(raddr_a[j]) || !RESET_N) rd_c = '0;
    end

    assign RDATA[slice_hi(j, DATA_WIDTH):slice_lo(j, DATA_WIDTH)] = rd_c;
  end

  // Debug port always shows the stored value
  assign DBG_DATA = (!RESET_N || addr_zero(DBG_ADDR)) ? '0 : regs_q[DBG_ADDR];

  reg_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG),
    .BYPASS     (BYPASS)
  ) u_scoreboard (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .WE       (WE),
    .WADDR    (WADDR),
    .RSV_EN   (RSV_EN),
    .RSV_ADDR (RSV_ADDR),
    .RADDR    (RADDR),
    .RBUSY    (RBUSY)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed checks of the default register file plus a randomized model run of a 4R/1W 16-bit variant.
module tb_reg_file_mp;

  logic        clk;
  logic        rst_n;

  // Default configuration: 32-bit, 2R/2W, zero reg, bypass
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        wr_conflict;

  // Regression configuration: 16-bit, 4R/1W, no bypass
  logic [0:0]  we2;
  logic [4:0]  waddr2;
  logic [15:0] wdata2;
  logic [19:0] raddr2;
  logic [63:0] rdata2;
  logic [3:0]  rbusy2;
  logic        rsv_en2;
  logic [4:0]  rsv_addr2;
  logic [4:0]  dbg_addr2;
  logic [15:0] dbg_data2;
  logic        wr_conflict2;

  int n_vec;
  int n_miss;

  logic [15:0] m_mem [32];
  logic [31:0] m_busy;

  reg_file_mp dut (
    .CLK(clk), .RESET_N(rst_n), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RADDR(raddr), .RDATA(rdata), .RBUSY(rbusy), .RSV_EN(rsv_en), .RSV_ADDR(rsv_addr),
    .DBG_ADDR(dbg_addr), .DBG_DATA(dbg_data), .WR_CONFLICT(wr_conflict)
  );

  reg_file_mp #(
    .DATA_WIDTH(16), .ADDR_WIDTH(5), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1), .BYPASS(0)
  ) dut2 (
    .CLK(clk), .RESET_N(rst_n), .WE(we2), .WADDR(waddr2), .WDATA(wdata2),
    .RADDR(raddr2), .RDATA(rdata2), .RBUSY(rbusy2), .RSV_EN(rsv_en2), .RSV_ADDR(rsv_addr2),
    .DBG_ADDR(dbg_addr2), .DBG_DATA(dbg_data2), .WR_CONFLICT(wr_conflict2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we     = 2'b00;
    rsv_en = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    we = '0; waddr = '0; wdata = '0; raddr = '0; rsv_en = 1'b0; rsv_addr = '0; dbg_addr = '0;
    we2 = '0; waddr2 = '0; wdata2 = '0; raddr2 = '0; rsv_en2 = 1'b0; rsv_addr2 = '0; dbg_addr2 = '0;

    // Writes and reserves during reset are ignored and bypass is suppressed
    #2;
    we = 2'b01; waddr[4:0] = 5'd4; wdata[31:0] = 32'h0000_CAFE;
    raddr[4:0] = 5'd4; rsv_en = 1'b1; rsv_addr = 5'd4; dbg_addr = 5'd4;
    @(posedge clk); #1;
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rbusy0", 32'(rbusy[0]), 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    chk("rst_conflict", 32'(wr_conflict), 32'h0);

    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk("rst_wr_ignored", rdata[31:0], 32'h0);
    chk("rst_rsv_ignored", 32'(rbusy[0]), 32'h0);

    // Port 0 write with same-cycle bypass, then stored read
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEAD_BEEF;
    raddr = {5'd5, 5'd5}; dbg_addr = 5'd5;
    #1;
    chk("byp_rd0", rdata[31:0], 32'hDEAD_BEEF);
    chk("byp_rd1", rdata[63:32], 32'hDEAD_BEEF);
    chk("dbg_no_byp", dbg_data, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("stored_rd0", rdata[31:0], 32'hDEAD_BEEF);
    chk("stored_dbg", dbg_data, 32'hDEAD_BEEF);
    chk("no_conflict_a", 32'(wr_conflict), 32'h0);

    // Both ports write address 7: port 1 wins, conflict flagged for one cycle
    @(negedge clk);
    we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h0000_0022, 32'h0000_0011};
    raddr = {5'd5, 5'd7}; dbg_addr = 5'd7;
    #1;
    chk("coll_byp", rdata[31:0], 32'h0000_0022);
    chk("coll_conf_pre", 32'(wr_conflict), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("coll_stored", rdata[31:0], 32'h0000_0022);
    chk("coll_dbg", dbg_data, 32'h0000_0022);
    chk("coll_conf", 32'(wr_conflict), 32'h1);
    @(negedge clk);
    #1;
    chk("coll_conf_clr", 32'(wr_conflict), 32'h0);

    // Distinct addresses on both ports: no conflict, independent bypass
    @(negedge clk);
    we = 2'b11; waddr = {5'd11, 5'd10}; wdata = {32'hBBBB_0011, 32'hAAAA_0010};
    raddr = {5'd11, 5'd10};
    #1;
    chk("dual_byp0", rdata[31:0], 32'hAAAA_0010);
    chk("dual_byp1", rdata[63:32], 32'hBBBB_0011);
    @(negedge clk);
    idle();
    raddr = {5'd10, 5'd11};
    #1;
    chk("dual_st0", rdata[31:0], 32'hBBBB_0011);
    chk("dual_st1", rdata[63:32], 32'hAAAA_0010);
    chk("dual_noconf", 32'(wr_conflict), 32'h0);

    // Both ports write all-ones to address 0: discarded, no conflict
    @(negedge clk);
    we = 2'b11; waddr = {5'd0, 5'd0}; wdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    raddr = {5'd0, 5'd0}; dbg_addr = 5'd0;
    #1;
    chk("z_byp", rdata[31:0], 32'h0);
    chk("z_dbg_w", dbg_data, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("z_rd0", rdata[31:0], 32'h0);
    chk("z_rd1", rdata[63:32], 32'h0);
    chk("z_dbg", dbg_data, 32'h0);
    chk("z_noconf", 32'(wr_conflict), 32'h0);

    // Scoreboard: reserve, write clears (with bypass), reserve+write sets
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd3; raddr = {5'd3, 5'd3};
    #1;
    chk("sb_rsv_same", 32'(rbusy[0]), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("sb_busy0", 32'(rbusy[0]), 32'h1);
    chk("sb_busy1", 32'(rbusy[1]), 32'h1);
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'h0000_0033;
    #1;
    chk("sb_wr_byp", 32'(rbusy[0]), 32'h0);
    chk("sb_wr_data", rdata[31:0], 32'h0000_0033);
    @(negedge clk);
    idle();
    #1;
    chk("sb_cleared", 32'(rbusy[0]), 32'h0);
    @(negedge clk);
    #1;
    chk("sb_stays", 32'(rbusy[1]), 32'h0);
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'h0000_0044; rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    chk("sb_rw_same", 32'(rbusy[0]), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("sb_rw_set", 32'(rbusy[0]), 32'h1);
    chk("sb_rw_data", rdata[31:0], 32'h0000_0044);
    @(negedge clk);
    we = 2'b10; waddr[9:5] = 5'd3; wdata[63:32] = 32'h0000_0055;
    #1;
    chk("sb_p1_byp", 32'(rbusy[1]), 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("sb_p1_clr", 32'(rbusy[0]), 32'h0);
    chk("sb_p1_data", rdata[63:32], 32'h0000_0055);

    // Reserve to address 0 is ignored
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd0; raddr = {5'd0, 5'd3};
    @(negedge clk);
    idle();
    #1;
    chk("sb_zero", 32'(rbusy[1]), 32'h0);

    // Load 9, reserve 9, then asynchronous reset between edges
    @(negedge clk);
    we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h0000_1234;
    @(negedge clk);
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    @(negedge clk);
    idle();
    raddr = {5'd9, 5'd9}; dbg_addr = 5'd9;
    #1;
    chk("ar_pre_rd", rdata[31:0], 32'h0000_1234);
    chk("ar_pre_busy", 32'(rbusy[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_rd", rdata[31:0], 32'h0);
    chk("ar_busy", 32'(rbusy[0]), 32'h0);
    chk("ar_dbg", dbg_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_rd_after", rdata[63:32], 32'h0);
    chk("ar_busy_after", 32'(rbusy[1]), 32'h0);

    // Randomized run of the 4R/1W no-bypass variant against a reference model
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_busy = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      we2       = 1'($urandom);
      waddr2    = 5'($urandom);
      wdata2    = 16'($urandom);
      raddr2    = 20'($urandom);
      rsv_en2   = ($urandom_range(0, 2) == 0);
      rsv_addr2 = 5'($urandom);
      dbg_addr2 = 5'($urandom);
      if ((c % 7) == 0) raddr2[4:0] = waddr2;
      #1;
      for (int j = 0; j < 4; j++) begin
        chk("rg_rdata", 32'(rdata2[j*16 +: 16]), 32'(m_mem[raddr2[j*5 +: 5]]));
        chk("rg_rbusy", 32'(rbusy2[j]), 32'(m_busy[raddr2[j*5 +: 5]]));
      end
      chk("rg_dbg", 32'(dbg_data2), 32'(m_mem[dbg_addr2]));
      chk("rg_conflict", 32'(wr_conflict2), 32'h0);
      @(posedge clk);
      if (we2[0] && (waddr2 != 5'd0)) m_mem[waddr2] = wdata2;
      if (we2[0]) m_busy[waddr2] = 1'b0;
      if (rsv_en2 && (rsv_addr2 != 5'd0)) m_busy[rsv_addr2] = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
